// File: rtl/enet_gmii_tx_framer_pkg.sv
// Shared Ethernet constants and the transmit framer state type.
// The CRC constants are also used by the receive-side checker.
package enet_pkg;

  localparam logic [7:0]  ENET_PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  ENET_SFD_BYTE      = 8'hD5;
  localparam logic [31:0] ENET_CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] ENET_CRC_INIT      = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_DRAIN,
    ST_IFG
  } txState_t;

endpackage

// File: rtl/enet_gmii_tx_framer_if.sv
// Byte-stream handshake (valid/ready/last/user) feeding the GMII transmit framer.
interface enet_gmii_tx_framer_if;

  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tready;
  logic       s_tlast;
  logic       s_tuser;

  modport master (output s_tdata, s_tvalid, s_tlast, s_tuser, input s_tready);
  modport slave  (input s_tdata, s_tvalid, s_tlast, s_tuser, output s_tready);

endinterface

// File: rtl/enet_crc32_d8.sv
// Combinational IEEE 802.3 CRC-32 step over one byte (reflected form).
// Shared by the transmit framer and the receive checker.
module enet_crc32_d8
  import enet_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  logic [31:0] w_crc;

  always_comb begin
    w_crc = crc_in ^ {24'h000000, data_in};
    for (int i = 0; i < 8; i++) begin
      w_crc = w_crc[0] ? ((w_crc >> 1) ^ ENET_CRC_POLY) : (w_crc >> 1);
    end
    crc_out = w_crc;
  end

endmodule

// File: rtl/enet_gmii_tx_framer.sv
// GMII transmit framer: preamble, SFD, payload, zero pad, FCS, inter-frame gap.
// Underrun and abort are flagged on gmii_tx_er; every GMII output is registered.
module enet_gmii_tx_framer
  import enet_pkg::*;
#(
  parameter int PREAMBLE_BYTES = 7,
  parameter int MIN_FRAME_LEN  = 60,
  parameter int IFG_BYTES      = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  enet_gmii_tx_framer_if.slave s_if,
  output logic                 gmii_tx_en,
  output logic                 gmii_tx_er,
  output logic [7:0]           gmii_txd,
  output logic                 tx_busy,
  output logic                 stat_frame_done,
  output logic                 stat_error
);

  localparam logic [7:0]  LP_PRE_LAST = 8'(PREAMBLE_BYTES);
  localparam logic [7:0]  LP_IFG_LAST = 8'(IFG_BYTES - 1);
  localparam logic [15:0] LP_MIN_LEN  = 16'(MIN_FRAME_LEN);

  txState_t    r_state;
  logic [7:0]  r_cnt;
  logic [15:0] r_byteCount;
  logic [31:0] r_crc;
  logic        r_txEn;
  logic        r_txEr;
  logic [7:0]  r_txd;
  logic        r_statDone;
  logic        r_statErr;

  logic [7:0]  w_crcByte;
  logic [31:0] w_crcNext;
  logic [31:0] w_fcs;
  logic [15:0] w_countNext;

  // Pad bytes are zeros that still count toward the FCS.
  assign w_crcByte   = (r_state == ST_PAD) ? 8'h00 : s_if.s_tdata;
  assign w_fcs       = ~r_crc;
  assign w_countNext = (r_byteCount == 16'hFFFF) ? r_byteCount : r_byteCount + 16'd1;

  enet_crc32_d8 u_crc (
    .crc_in  (r_crc),
    .data_in (w_crcByte),
    .crc_out (w_crcNext)
  );

  assign s_if.s_tready   = (r_state == ST_SFD) || (r_state == ST_DATA) || (r_state == ST_DRAIN);
  assign tx_busy         = (r_state != ST_IDLE);
  assign gmii_tx_en      = r_txEn;
  assign gmii_tx_er      = r_txEr;
  assign gmii_txd        = r_txd;
  assign stat_frame_done = r_statDone;
  assign stat_error      = r_statErr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 8'd0;
      r_byteCount <= 16'd0;
      r_crc       <= ENET_CRC_INIT;
      r_txEn      <= 1'b0;
      r_txEr      <= 1'b0;
      r_txd       <= 8'h00;
      r_statDone  <= 1'b0;
      r_statErr   <= 1'b0;
    end else begin
      r_txEr     <= 1'b0;
      r_statDone <= 1'b0;
      r_statErr  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_txEn <= 1'b0;
          r_txd  <= 8'h00;
          if (s_if.s_tvalid) begin
            r_state     <= ST_PRE;
            r_txEn      <= 1'b1;
            r_txd       <= ENET_PREAMBLE_BYTE;
            r_cnt       <= 8'd1;
            r_crc       <= ENET_CRC_INIT;
            r_byteCount <= 16'd0;
          end
        end
        ST_PRE: begin
          r_txEn <= 1'b1;
          if (r_cnt == LP_PRE_LAST) begin
            r_txd   <= ENET_SFD_BYTE;
            r_state <= ST_SFD;
          end else begin
            r_txd <= ENET_PREAMBLE_BYTE;
            r_cnt <= r_cnt + 8'd1;
          end
        end
        // The SFD cycle already accepts the first payload byte.
        ST_SFD, ST_DATA: begin
          r_txEn <= 1'b1;
          r_cnt  <= 8'd0;
          if (s_if.s_tvalid) begin
            r_txd       <= s_if.s_tdata;
            r_crc       <= w_crcNext;
            r_byteCount <= w_countNext;
            if (s_if.s_tuser) begin
              r_txEr    <= 1'b1;
              r_statErr <= 1'b1;
              r_state   <= s_if.s_tlast ? ST_IFG : ST_DRAIN;
            end else if (s_if.s_tlast) begin
              r_state <= (w_countNext < LP_MIN_LEN) ? ST_PAD : ST_FCS;
            end else begin
              r_state <= ST_DATA;
            end
          end else begin
            r_txEr    <= 1'b1;
            r_txd     <= 8'h00;
            r_statErr <= 1'b1;
            r_state   <= ST_DRAIN;
          end
        end
        ST_PAD: begin
          r_txEn      <= 1'b1;
          r_txd       <= 8'h00;
          r_crc       <= w_crcNext;
          r_byteCount <= w_countNext;
          if (w_countNext >= LP_MIN_LEN) begin
            r_state <= ST_FCS;
            r_cnt   <= 8'd0;
          end
        end
        ST_FCS: begin
          r_txEn <= 1'b1;
          r_txd  <= w_fcs[{r_cnt[1:0], 3'b000} +: 8];
          if (r_cnt == 8'd3) begin
            r_state <= ST_IFG;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_DRAIN: begin
          r_txEn <= 1'b0;
          r_txd  <= 8'h00;
          if (s_if.s_tvalid && s_if.s_tlast) begin
            r_state <= ST_IFG;
            r_cnt   <= 8'd0;
          end
        end
        // Only a good frame leaves tx_en high without tx_er on entry here.
        ST_IFG: begin
          r_txEn     <= 1'b0;
          r_txd      <= 8'h00;
          r_statDone <= (r_cnt == 8'd0) && r_txEn && !r_txEr;
          if (r_cnt == LP_IFG_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enet_gmii_tx_framer.sv
// Directed bench for enet_gmii_tx_framer: one DUT without padding, one with defaults.
// Output bytes are captured every cycle and compared against hand-derived sequences.
module tb_enet_gmii_tx_framer;

  typedef struct packed {
    logic       en;
    logic       er;
    logic [7:0] d;
  } sample_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #4 clk = ~clk;

  enet_gmii_tx_framer_if if0 ();
  enet_gmii_tx_framer_if if1 ();

  logic [7:0] drvData  = 8'h00;
  logic       drvValid = 1'b0;
  logic       drvLast  = 1'b0;
  logic       drvUser  = 1'b0;
  int         sel      = 1;
  logic       drvReady;

  assign if0.s_tdata  = drvData;
  assign if0.s_tvalid = drvValid && (sel == 0);
  assign if0.s_tlast  = drvLast;
  assign if0.s_tuser  = drvUser;
  assign if1.s_tdata  = drvData;
  assign if1.s_tvalid = drvValid && (sel == 1);
  assign if1.s_tlast  = drvLast;
  assign if1.s_tuser  = drvUser;
  assign drvReady     = (sel == 0) ? if0.s_tready : if1.s_tready;

  logic       en0, er0, busy0, done0, err0;
  logic [7:0] txd0;
  logic       en1, er1, busy1, done1, err1;
  logic [7:0] txd1;

  enet_gmii_tx_framer #(.PREAMBLE_BYTES(7), .MIN_FRAME_LEN(0), .IFG_BYTES(12)) u_dut0 (
    .clk(clk), .rst(rst), .s_if(if0),
    .gmii_tx_en(en0), .gmii_tx_er(er0), .gmii_txd(txd0),
    .tx_busy(busy0), .stat_frame_done(done0), .stat_error(err0)
  );

  enet_gmii_tx_framer #(.PREAMBLE_BYTES(7), .MIN_FRAME_LEN(60), .IFG_BYTES(12)) u_dut1 (
    .clk(clk), .rst(rst), .s_if(if1),
    .gmii_tx_en(en1), .gmii_tx_er(er1), .gmii_txd(txd1),
    .tx_busy(busy1), .stat_frame_done(done1), .stat_error(err1)
  );

  int nChecks = 0;
  int nFails  = 0;

  sample_t    tr0[$];
  sample_t    tr1[$];
  int         doneCnt0 = 0, errCnt0 = 0, doneCnt1 = 0, errCnt1 = 0;
  logic [7:0] payload[256];
  logic [7:0] refBuf[256];

  always @(negedge clk) begin
    tr0.push_back({en0, er0, txd0});
    tr1.push_back({en1, er1, txd1});
    if (done0) doneCnt0++;
    if (err0)  errCnt0++;
    if (done1) doneCnt1++;
    if (err1)  errCnt1++;
  end

  // Bit-serial reference CRC, independent of the byte-wide hardware step.
  function automatic logic [31:0] crcRef(input int n);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ refBuf[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  function automatic sample_t getS(input int s, input int k);
    if (s == 0) return (k < tr0.size()) ? tr0[k] : '0;
    return (k < tr1.size()) ? tr1[k] : '0;
  endfunction

  function automatic int countEn(input int s);
    int n = 0;
    int sz = (s == 0) ? tr0.size() : tr1.size();
    for (int k = 0; k < sz; k++) if (getS(s, k).en) n++;
    return n;
  endfunction

  function automatic int countEr(input int s);
    int n = 0;
    int sz = (s == 0) ? tr0.size() : tr1.size();
    for (int k = 0; k < sz; k++) if (getS(s, k).er) n++;
    return n;
  endfunction

  task automatic clearTrace();
    tr0.delete();
    tr1.delete();
    doneCnt0 = 0; errCnt0 = 0; doneCnt1 = 0; errCnt1 = 0;
  endtask

  task automatic waitAccept(output bit ok);
    logic rdy;
    int   k;
    k = 0;
    do begin
      rdy = drvReady;
      @(posedge clk); #1;
      k++;
    end while (!rdy && k < 200);
    ok = rdy;
  endtask

  task automatic sendFrame(input int s, input int n, input int abortIdx,
                           input int stallAfter, input int stallCycles);
    bit ok;
    sel = s;
    for (int i = 0; i < n; i++) begin
      if (i == stallAfter) begin
        drvValid = 1'b0;
        repeat (stallCycles) begin @(posedge clk); #1; end
      end
      drvValid = 1'b1;
      drvData  = payload[i];
      drvLast  = (i == n - 1);
      drvUser  = (i == abortIdx);
      waitAccept(ok);
      if (!ok) begin
        nChecks++; nFails++;
        $display("[TB] FAIL accept_timeout: byte %0d of %0d not accepted, required ready within 200 cycles", i, n);
        break;
      end
    end
    drvValid = 1'b0;
    drvLast  = 1'b0;
    drvUser  = 1'b0;
  endtask

  task automatic waitIdle(input int s);
    int k = 0;
    while (((s == 0) ? busy0 : busy1) && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    if ((s == 0) ? busy0 : busy1) begin
      nChecks++; nFails++;
      $display("[TB] FAIL idle_timeout: tx_busy still 1, required 0 within 400 cycles");
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nChecks++; if (en1 !== 1'b0)    begin nFails++; $display("[TB] FAIL reset_tx_en: got %b required 0", en1); end
    nChecks++; if (er1 !== 1'b0)    begin nFails++; $display("[TB] FAIL reset_tx_er: got %b required 0", er1); end
    nChecks++; if (txd1 !== 8'h00)  begin nFails++; $display("[TB] FAIL reset_txd: got %h required 00", txd1); end
    nChecks++; if (busy1 !== 1'b0)  begin nFails++; $display("[TB] FAIL reset_busy: got %b required 0", busy1); end
    nChecks++; if (if1.s_tready !== 1'b0) begin nFails++; $display("[TB] FAIL reset_tready: got %b required 0", if1.s_tready); end
    nChecks++; if (en0 !== 1'b0)    begin nFails++; $display("[TB] FAIL reset_tx_en0: got %b required 0", en0); end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    nChecks++; if ({done1, err1, en1} !== 3'b000) begin nFails++; $display("[TB] FAIL post_reset_idle: got %b required 000", {done1, err1, en1}); end
  endtask

  task automatic test_check_string();
    sample_t     got;
    logic [31:0] fcsLit;
    logic [9:0]  exp;
    fcsLit = 32'hCBF43926;
    for (int i = 0; i < 9; i++) payload[i] = 8'(8'h31 + i);
    clearTrace();
    sendFrame(0, 9, -1, -1, 0);
    waitIdle(0);
    for (int k = 0; k <= 22; k++) begin
      if (k == 0 || k == 22)  exp = {2'b00, 8'h00};
      else if (k <= 7)        exp = {2'b10, 8'h55};
      else if (k == 8)        exp = {2'b10, 8'hD5};
      else if (k <= 17)       exp = {2'b10, 8'(8'h31 + (k - 9))};
      else                    exp = {2'b10, fcsLit[8*(k-18) +: 8]};
      got = getS(0, k);
      nChecks++;
      if ({got.en, got.er, got.d} !== exp) begin
        nFails++;
        $display("[TB] FAIL crc_string_byte%0d: got en/er/d %b/%b/%h required %b/%b/%h", k, got.en, got.er, got.d, exp[9], exp[8], exp[7:0]);
      end
    end
    nChecks++; if (countEn(0) != 21) begin nFails++; $display("[TB] FAIL crc_string_en_cycles: got %0d required 21", countEn(0)); end
    nChecks++; if (countEr(0) != 0)  begin nFails++; $display("[TB] FAIL crc_string_er_cycles: got %0d required 0", countEr(0)); end
    nChecks++; if (doneCnt0 != 1)    begin nFails++; $display("[TB] FAIL crc_string_done: got %0d required 1", doneCnt0); end
    nChecks++; if (errCnt0 != 0)     begin nFails++; $display("[TB] FAIL crc_string_err: got %0d required 0", errCnt0); end
  endtask

  task automatic test_padding();
    logic [31:0] fcs;
    int          bad;
    for (int i = 0; i < 14; i++) payload[i] = 8'(8'hA0 + i);
    for (int i = 0; i < 60; i++) refBuf[i] = (i < 14) ? payload[i] : 8'h00;
    fcs = crcRef(60);
    clearTrace();
    sendFrame(1, 14, -1, -1, 0);
    waitIdle(1);
    bad = 0;
    for (int k = 9; k <= 22; k++) if (getS(1, k) !== {2'b10, payload[k-9]}) bad++;
    nChecks++; if (bad != 0) begin nFails++; $display("[TB] FAIL pad_payload: got %0d wrong bytes required 0", bad); end
    bad = 0;
    for (int k = 23; k <= 68; k++) if (getS(1, k) !== {2'b10, 8'h00}) bad++;
    nChecks++; if (bad != 0) begin nFails++; $display("[TB] FAIL pad_zeros: got %0d wrong pad bytes required 0", bad); end
    for (int j = 0; j < 4; j++) begin
      nChecks++;
      if (getS(1, 69 + j) !== {2'b10, fcs[8*j +: 8]}) begin
        nFails++;
        $display("[TB] FAIL pad_fcs%0d: got %h required %h", j, getS(1, 69 + j).d, fcs[8*j +: 8]);
      end
    end
    nChecks++; if (getS(1, 73).en !== 1'b0) begin nFails++; $display("[TB] FAIL pad_end: got tx_en %b required 0", getS(1, 73).en); end
    nChecks++; if (countEn(1) != 72) begin nFails++; $display("[TB] FAIL pad_en_cycles: got %0d required 72", countEn(1)); end
    nChecks++; if (doneCnt1 != 1)    begin nFails++; $display("[TB] FAIL pad_done: got %0d required 1", doneCnt1); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] fcs;
    int          a, b, e;
    for (int i = 0; i < 64; i++) begin
      payload[i] = 8'(i * 7 + 3);
      refBuf[i]  = payload[i];
    end
    fcs = crcRef(64);
    clearTrace();
    sendFrame(1, 64, -1, -1, 0);
    sendFrame(1, 64, -1, -1, 0);
    waitIdle(1);
    a = 0;
    while (a < tr1.size() && !getS(1, a).en) a++;
    b = a;
    while (b < tr1.size() && getS(1, b).en) b++;
    e = b;
    while (e < tr1.size() && !getS(1, e).en) e++;
    nChecks++; if (a != 1)  begin nFails++; $display("[TB] FAIL b2b_first_pre: got index %0d required 1", a); end
    nChecks++; if (b != 77) begin nFails++; $display("[TB] FAIL b2b_frame1_end: got index %0d required 77", b); end
    nChecks++; if (e - b != 12) begin nFails++; $display("[TB] FAIL b2b_ifg: got %0d idle cycles required 12", e - b); end
    nChecks++; if (getS(1, e).d !== 8'h55) begin nFails++; $display("[TB] FAIL b2b_second_pre: got %h required 55", getS(1, e).d); end
    nChecks++; if (getS(1, b - 1).d !== fcs[31:24]) begin nFails++; $display("[TB] FAIL b2b_last_fcs: got %h required %h", getS(1, b - 1).d, fcs[31:24]); end
    nChecks++; if (countEn(1) != 152) begin nFails++; $display("[TB] FAIL b2b_en_cycles: got %0d required 152", countEn(1)); end
    nChecks++; if (doneCnt1 != 2) begin nFails++; $display("[TB] FAIL b2b_done: got %0d required 2", doneCnt1); end
  endtask

  task automatic test_underrun();
    int bad;
    for (int i = 0; i < 30; i++) payload[i] = 8'(8'hC0 + i);
    clearTrace();
    sendFrame(1, 30, -1, 20, 3);
    waitIdle(1);
    bad = 0;
    for (int k = 9; k <= 28; k++) if (getS(1, k) !== {2'b10, payload[k-9]}) bad++;
    nChecks++; if (bad != 0) begin nFails++; $display("[TB] FAIL underrun_payload: got %0d wrong bytes required 0", bad); end
    nChecks++; if (getS(1, 29) !== {2'b11, 8'h00}) begin nFails++; $display("[TB] FAIL underrun_marker: got en/er/d %b/%b/%h required 1/1/00", getS(1, 29).en, getS(1, 29).er, getS(1, 29).d); end
    nChecks++; if (countEn(1) != 29) begin nFails++; $display("[TB] FAIL underrun_en_cycles: got %0d required 29", countEn(1)); end
    nChecks++; if (countEr(1) != 1)  begin nFails++; $display("[TB] FAIL underrun_er_cycles: got %0d required 1", countEr(1)); end
    nChecks++; if (errCnt1 != 1)     begin nFails++; $display("[TB] FAIL underrun_stat_error: got %0d required 1", errCnt1); end
    nChecks++; if (doneCnt1 != 0)    begin nFails++; $display("[TB] FAIL underrun_done: got %0d required 0", doneCnt1); end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 30; i++) payload[i] = 8'(8'h10 + i);
    clearTrace();
    sendFrame(1, 30, 4, -1, 0);
    waitIdle(1);
    nChecks++; if (getS(1, 12) !== {2'b10, payload[3]}) begin nFails++; $display("[TB] FAIL abort_prev_byte: got %h er %b required %h er 0", getS(1, 12).d, getS(1, 12).er, payload[3]); end
    nChecks++; if (getS(1, 13) !== {2'b11, payload[4]}) begin nFails++; $display("[TB] FAIL abort_byte: got en/er/d %b/%b/%h required 1/1/%h", getS(1, 13).en, getS(1, 13).er, getS(1, 13).d, payload[4]); end
    nChecks++; if (countEn(1) != 13) begin nFails++; $display("[TB] FAIL abort_en_cycles: got %0d required 13", countEn(1)); end
    nChecks++; if (errCnt1 != 1)     begin nFails++; $display("[TB] FAIL abort_stat_error: got %0d required 1", errCnt1); end
    nChecks++; if (doneCnt1 != 0)    begin nFails++; $display("[TB] FAIL abort_done: got %0d required 0", doneCnt1); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] fcs;
    sel = 1;
    clearTrace();
    drvValid = 1'b1; drvData = 8'h77; drvLast = 1'b0; drvUser = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    nChecks++; if (en1 !== 1'b1) begin nFails++; $display("[TB] FAIL midrst_pre_en: got %b required 1", en1); end
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    nChecks++; if ({en1, er1, txd1} !== 10'h000) begin nFails++; $display("[TB] FAIL midrst_async: got en/er/d %b/%b/%h required 0/0/00", en1, er1, txd1); end
    nChecks++; if (busy1 !== 1'b0) begin nFails++; $display("[TB] FAIL midrst_busy: got %b required 0", busy1); end
    drvValid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) begin
      payload[i] = 8'(255 - i);
      refBuf[i]  = payload[i];
    end
    fcs = crcRef(64);
    clearTrace();
    sendFrame(1, 64, -1, -1, 0);
    waitIdle(1);
    nChecks++; if (getS(1, 1) !== {2'b10, 8'h55}) begin nFails++; $display("[TB] FAIL midrst_preamble: got %h required 55", getS(1, 1).d); end
    nChecks++; if (getS(1, 8) !== {2'b10, 8'hD5}) begin nFails++; $display("[TB] FAIL midrst_sfd: got %h required D5", getS(1, 8).d); end
    for (int j = 0; j < 4; j++) begin
      nChecks++;
      if (getS(1, 73 + j) !== {2'b10, fcs[8*j +: 8]}) begin
        nFails++;
        $display("[TB] FAIL midrst_fcs%0d: got %h required %h", j, getS(1, 73 + j).d, fcs[8*j +: 8]);
      end
    end
    nChecks++; if (doneCnt1 != 1) begin nFails++; $display("[TB] FAIL midrst_done: got %0d required 1", doneCnt1); end
  endtask

  initial begin
    test_reset();
    test_check_string();
    test_padding();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
